// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared state encoding, lane width and tag field layout for the stream arbiter
package stream_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int LANE_W  = 128;
    localparam int GID_W   = 3;
    localparam int TAG_MSB = 127;
    localparam int TAG_LSB = 120;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic priority search starting after the last grantee
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N_IN = 4
)
(
    input  logic [N_IN-1:0]  i_req,
    input  logic [GID_W-1:0] i_last,
    output logic             o_hit,
    output logic [GID_W-1:0] o_idx
);

    int                w_pos;
    logic [N_IN-1:0]   w_mask;

    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        w_pos  = 0;
        w_mask = '0;
        // Walk from farthest to nearest so the nearest requester after i_last is the final writer.
        for (int k = N_IN; k >= 1; k--) begin
            w_pos  = (int'(i_last) + k) % N_IN;
            w_mask = N_IN'(1) << w_pos;
            if (|(i_req & w_mask)) begin
                o_hit = 1'b1;
                o_idx = GID_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin burst arbiter of N_IN streams into one registered output stage
// Optional source tag in s1o_data[127:120] when STREAM_ARB_TAG_EN is defined.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int BURST_MAX = 16
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_rdy,
    input  logic [LANE_W*N_IN-1:0] in_data,
    output logic                   s1o_valid,
    input  logic                   s1o_rdy,
    output logic [LANE_W-1:0]      s1o_data,
    output logic [GID_W-1:0]       grant_id
);

    // Compare against the last beat index so BURST_MAX=256 still fits the 8-bit counter.
    localparam logic [7:0]       LP_LAST_BEAT = 8'(BURST_MAX - 1);
    localparam logic [GID_W-1:0] LP_LAST_RST  = GID_W'(N_IN - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [GID_W-1:0]  r_grant;
    logic [GID_W-1:0]  r_last_grant;
    logic [7:0]        r_beat_cnt;
    logic              r_out_valid;
    logic [LANE_W-1:0] r_out_data;
    logic [LANE_W-1:0] w_sel_data;
    logic [LANE_W-1:0] w_beat;
    logic [GID_W-1:0]  w_pick_idx;
    logic              w_pick_hit;
    logic              w_out_free;
    logic              w_gnt_valid;
    logic              w_accept;

    rr_pick #(.N_IN(N_IN)) u_pick (
        .i_req  (in_valid),
        .i_last (r_last_grant),
        .o_hit  (w_pick_hit),
        .o_idx  (w_pick_idx)
    );

    assign w_out_free = ~r_out_valid | s1o_rdy;

    always_comb begin
        w_sel_data  = '0;
        w_gnt_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (r_grant == GID_W'(i)) begin
                w_sel_data  = in_data[LANE_W*i +: LANE_W];
                w_gnt_valid = in_valid[i];
            end
        end
    end

`ifdef STREAM_ARB_TAG_EN
    assign w_beat = {{(TAG_MSB - TAG_LSB + 1 - GID_W){1'b0}}, r_grant, w_sel_data[TAG_LSB-1:0]};
`else
    assign w_beat = w_sel_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_rdy      = '0;
        w_accept    = 1'b0;
        case (r_state)
            ARB: begin
                if (w_pick_hit) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                // Gating with rst stops a source from handing over a beat the reset will discard.
                for (int i = 0; i < N_IN; i++) begin
                    if (r_grant == GID_W'(i)) begin
                        in_rdy[i] = w_out_free & ~rst;
                    end
                end
                w_accept = w_gnt_valid & w_out_free;
                if (w_out_free && !w_gnt_valid) begin
                    w_state_nxt = ARB;
                end else if (w_accept && r_beat_cnt == LP_LAST_BEAT) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_beat_cnt   <= '0;
            r_grant      <= '0;
            r_last_grant <= LP_LAST_RST;
        end else begin
            if (r_state == ARB && w_pick_hit) begin
                r_grant    <= w_pick_idx;
                r_beat_cnt <= '0;
            end
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (r_state == XFER && w_state_nxt == ARB) begin
                r_last_grant <= r_grant;
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (s1o_rdy) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_out_data <= w_beat;
        end
    end

    assign s1o_valid = r_out_valid;
    assign s1o_data  = r_out_data;
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - self-checking bench for stream_rr_arbiter with a beat-order scoreboard
module tb_stream_rr_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst, rst1;
    logic [N-1:0]     in_valid, in_rdy, in_valid1, in_rdy1;
    logic [128*N-1:0] in_data, in_data1;
    logic             s1o_valid, s1o_rdy, s1o_valid1, s1o_rdy1;
    logic [127:0]     s1o_data, s1o_data1;
    logic [2:0]       grant_id, grant_id1;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.N_IN(N), .BURST_MAX(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rdy(in_rdy), .in_data(in_data),
        .s1o_valid(s1o_valid), .s1o_rdy(s1o_rdy), .s1o_data(s1o_data), .grant_id(grant_id)
    );

    stream_rr_arbiter #(.N_IN(N), .BURST_MAX(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_rdy(in_rdy1), .in_data(in_data1),
        .s1o_valid(s1o_valid1), .s1o_rdy(s1o_rdy1), .s1o_data(s1o_data1), .grant_id(grant_id1)
    );

    int          checks = 0;
    int          errors = 0;
    int          sent[N];
    int          lim[N];
    logic [N-1:0] want;
    int unsigned vprob, rprob;
    bit          ones2, rst_req;
    logic [127:0] exp_q[$];
    int          exp_order[5] = '{0, 1, 2, 3, 0};

    function automatic logic [127:0] mk(int i, int s);
        return 128'(i * 65536 + s);
    endfunction

    function automatic logic [127:0] xf(int i, logic [127:0] d);
`ifdef STREAM_ARB_TAG_EN
        return {5'b0, 3'(i), d[119:0]};
`else
        return d | 128'(i & 0);
`endif
    endfunction

    function automatic bit all_sent();
        for (int i = 0; i < N; i++) if (sent[i] < lim[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        rst = rst_req;
        for (int i = 0; i < N; i++) begin
            in_data[128*i +: 128] = (ones2 && i == 2) ? {128{1'b1}} : mk(i, sent[i]);
            in_valid[i] = want[i] && (sent[i] < lim[i]) && ($urandom_range(99) < vprob);
        end
        s1o_rdy = ($urandom_range(99) < rprob);
    endtask

    // Reference: every accepted beat joins one global FIFO; outputs must leave in exactly that order.
    task automatic observe();
        if (rst) begin
            exp_q.delete();
            return;
        end
        chk("rdy_onehot", 128'($countones(in_rdy) > 1), 0);
        if (s1o_valid && s1o_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_extra: observed beat %0h expected none", s1o_data);
            end else begin
                chk("sb_beat", s1o_data, exp_q.pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_rdy[i]) begin
                exp_q.push_back(xf(i, in_data[128*i +: 128]));
                sent[i]++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic drain(string tag);
        want  = '0;
        rprob = 100;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || s1o_valid); k++) cyc();
        chk(tag, 128'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cyc();
        cyc();
        rst_req = 1'b0;
        cyc();
    endtask

    task automatic wait_valid(string tag);
        for (int k = 0; k < 50 && !s1o_valid; k++) cyc();
        chk(tag, s1o_valid, 1);
    endtask

    initial begin
        int           g, got, pend;
        logic [127:0] held, g_exp;
        int           acc_idx[$];
        int           acc_cyc[$];

        rst = 1'b1; rst1 = 1'b1; rst_req = 1'b1;
        want = '0; vprob = 100; rprob = 100; ones2 = 1'b0;
        in_valid = '0; s1o_rdy = 1'b1; in_data = '0;
        in_valid1 = '1; s1o_rdy1 = 1'b1;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            lim[i]  = 0;
            in_data1[128*i +: 128] = mk(i, 256);
        end

        // Reset values
        cyc();
        cyc();
        rst_req = 1'b0;
        chk("rst_valid", s1o_valid, 0);
        chk("rst_rdy", in_rdy, 0);
        chk("rst_gid", grant_id, 0);

        // Requesters 0 and 2 always valid: 16-beat grants alternating with one bubble
        for (int i = 0; i < N; i++) lim[i] = 1000;
        want = 4'b0101;
        wait_valid("b_start");
        for (int r = 0; r < 4; r++) begin
            g = (r % 2 == 0) ? 0 : 2;
            for (int j = 0; j < 16; j++) begin
                chk("b_valid", s1o_valid, 1);
                chk("b_data", s1o_data, xf(g, mk(g, (r / 2) * 16 + j)));
                chk("b_gid", grant_id, g);
                cyc();
            end
            chk("b_bubble", s1o_valid, 0);
            cyc();
        end
        drain("b_drain");

        // Requester 3 alone, three beats, then 0 must beat 1
        want = 4'b1000;
        lim[3] = sent[3] + 3;
        got = 0;
        for (int k = 0; k < 30 && got < 3; k++) begin
            if (s1o_valid && s1o_rdy) begin
                chk("c_beat", s1o_data, xf(3, 128'h30000 + 128'(got)));
                got++;
            end
            cyc();
        end
        chk("c_count", got, 3);
        cyc(); cyc(); cyc();
        chk("c_idle_rdy", in_rdy, 0);
        want = 4'b0011;
        for (int k = 0; k < 20 && in_rdy == 0; k++) cyc();
        chk("c_gid", grant_id, 0);
        chk("c_rdy", in_rdy, 4'b0001);
        drain("c_drain");

        // Output stall of 10 cycles mid-burst
        want = 4'b0001;
        lim[0] = sent[0] + 40;
        wait_valid("d_start");
        cyc(); cyc(); cyc();
        rprob = 0;
        cyc();
        held = s1o_data;
        chk("d_held_exp", held, exp_q.size() > 0 ? exp_q[0] : 128'hx);
        for (int j = 0; j < 10; j++) begin
            chk("d_valid", s1o_valid, 1);
            chk("d_hold", s1o_data, held);
            chk("d_rdy", in_rdy, 0);
            chk("d_gid", grant_id, 0);
            if (j < 9) cyc();
        end
        rprob = 100;
        for (int k = 0; k < 10; k++) cyc();
        drain("d_drain");

        // BURST_MAX=1 instance with all four requesters valid
        rst1 = 1'b0;
        pend = -1;
        for (int c = 0; c < 12; c++) begin
            if (pend >= 0) begin
                chk("e_ovalid", s1o_valid1, 1);
                chk("e_out", s1o_data1, xf(pend, mk(pend, 256)));
            end
            pend = -1;
            for (int i = 0; i < N; i++) begin
                if (in_valid1[i] && in_rdy1[i]) begin
                    acc_idx.push_back(i);
                    acc_cyc.push_back(c);
                    pend = i;
                end
            end
            cyc();
        end
        chk("e_count", acc_idx.size(), 6);
        for (int j = 0; j < 5 && j < acc_idx.size(); j++) chk("e_order", acc_idx[j], exp_order[j]);
        for (int j = 1; j < 5 && j < acc_cyc.size(); j++) chk("e_gap", acc_cyc[j] - acc_cyc[j-1], 2);

        // Reset while a beat is held in XFER
        want = 4'b0001;
        lim[0] = sent[0] + 40;
        wait_valid("f_pre_valid");
        chk("f_pre_rdy", in_rdy, 4'b0001);
        rst_req = 1'b1;
        cyc();
        rst_req = 1'b0;
        want = 4'b0010;
        lim[1] = sent[1] + 5;
        cyc();
        chk("f_valid", s1o_valid, 0);
        chk("f_rdy", in_rdy, 0);
        chk("f_gid", grant_id, 0);
        for (int k = 0; k < 20 && in_rdy == 0; k++) cyc();
        chk("f_new_gid", grant_id, 1);
        chk("f_new_rdy", in_rdy, 4'b0010);
        drain("f_drain");

        // Requester 2 sends all ones
        ones2 = 1'b1;
        want = 4'b0100;
        lim[2] = sent[2] + 1;
        wait_valid("g_start");
        g_exp = {128{1'b1}};
`ifdef STREAM_ARB_TAG_EN
        g_exp[127:120] = 8'h02;
`endif
        chk("g_tag", s1o_data, g_exp);
        drain("g_drain");
        ones2 = 1'b0;

        // Random valids and backpressure against the scoreboard
        do_reset();
        for (int i = 0; i < N; i++) lim[i] = sent[i] + 20 + int'($urandom_range(20));
        want = 4'b1111;
        vprob = 70;
        rprob = 60;
        for (int k = 0; k < 4000 && !(all_sent() && exp_q.size() == 0 && !s1o_valid); k++) cyc();
        chk("h_all_sent", all_sent(), 1);
        vprob = 100;
        drain("h_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of input streams (2..8).
REQ-002 SHALL have parameter BURST_MAX, default 16: maximum beats per grant (1..256).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, N_IN: per-requester beat valid.
REQ-006 SHALL have port in_rdy, output, N_IN: per-requester beat accepted when in_valid[i] and in_rdy[i] are both high.
REQ-007 SHALL have port in_data, input, 128*N_IN: requester i occupies bits [128*i+127:128*i].
REQ-008 SHALL have port s1o_valid, output, 1: output beat valid.
REQ-009 SHALL have port s1o_rdy, input, 1: downstream ready.
REQ-010 SHALL have port s1o_data, output, 128: output beat.
REQ-011 SHALL have port grant_id, output, 3: index of the current or most recent grantee, for debug.

Function
REQ-012 SHALL implement the FSM states ARB and XFER.
REQ-013 ARB SHALL pick the first requester with in_valid high, searching cyclically from last_grant+1.
  - On a hit: load grant_id, clear the beat counter, go to XFER next cycle.
  - With no requests: stay in ARB.
REQ-014 SHALL drive in_rdy low for every requester while in ARB, so each arbitration costs one bubble cycle.
REQ-015 In XFER, in_rdy[g] SHALL equal (~s1o_valid | s1o_rdy) for the grantee g; all other in_rdy bits SHALL be 0.
REQ-016 SHALL register each accepted beat into a single output stage.
  - s1o_data is the accepted beat; s1o_valid is set the next cycle.
  - Latency from input accept to s1o_valid is one cycle.
REQ-017 SHALL clear s1o_valid after s1o_rdy is sampled high, unless a new beat is accepted in the same cycle.
  - Simultaneous drain and accept keeps s1o_valid high with the new data.
REQ-018 SHALL keep s1o_data stable while s1o_valid is high and s1o_rdy is low.
REQ-019 SHALL increment the 8-bit beat counter on each accepted beat.
REQ-020 SHALL return from XFER to ARB and set last_grant to g in either case:
  - The counter reaches BURST_MAX.
  - In XFER, in_valid[g] is low in a cycle where in_rdy[g] is high.
REQ-021 SHALL NOT drop the grant while in_valid[g] is high and the output is stalled; it holds in XFER.
REQ-022 SHALL never drop, duplicate or reorder beats.
  - Per-requester order is preserved.
  - Beats from different grants are never interleaved inside one grant.

Reset
REQ-023 On rst, SHALL set state=ARB, s1o_valid=0, in_rdy=0, beat counter=0, grant_id=0 and last_grant=N_IN-1, so requester 0 wins first.
REQ-024 Reset asserted mid-burst SHALL discard the held output beat and, the following cycle, behave exactly as after power-up.
  - s1o_data value after reset is don't-care.

Configuration
REQ-025 SHALL insert the source tag when STREAM_ARB_TAG_EN is defined: s1o_data[127:120] = {5'b0, g} and s1o_data[119:0] = in_data bits [119:0].
REQ-026 Without STREAM_ARB_TAG_EN, s1o_data SHALL equal the accepted 128-bit beat unmodified.

Structure
REQ-027 SHALL place the FSM state encoding, the lane width (128) and the tag field position in the shared package stream_arb_pkg.
REQ-028 SHALL implement the cyclic priority search as sub-module rr_pick (inputs: request vector, last_grant; outputs: hit, index).
  - rr_pick is purely combinational.
  - No other sub-modules.

Verification
REQ-029 Bench SHALL drive reset, then in_valid=4'b0101 continuously with s1o_rdy=1.
  - Grants alternate 0,2,0,2.
  - Each grant lasts 16 beats, followed by one bubble cycle.
REQ-030 Bench SHALL drive only requester 3 with 3 beats of value 0x3_0000..0x3_0002, then drop valid.
  - Expect 3 output beats in order.
  - Expect return to ARB with last_grant=3.
  - Next request from 0 SHALL win before 1.
REQ-031 Bench SHALL hold s1o_rdy=0 for 10 cycles mid-burst.
  - s1o_data stays stable throughout.
  - in_rdy[g]=0 throughout.
  - No beat is lost after s1o_rdy returns to 1.
REQ-032 Bench SHALL drive all 4 requesters valid with BURST_MAX=1.
  - Grant order is 0,1,2,3,0.
  - Exactly one beat per grant.
REQ-033 Bench SHALL assert rst while s1o_valid=1 and state=XFER.
  - The next cycle shows s1o_valid=0 and in_rdy=0.
  - A new request from 1 is granted in ARB.
REQ-034 With STREAM_ARB_TAG_EN defined, requester 2 sends 0xFFFF...FF; output SHALL be 0x02FF...FF.
  - Without the macro, the output SHALL equal the input.
